// File: rtl/oam_dma.sv
// oam_dma: OAM DMA engine and CPU/DMA arbiter for the Game Boy memory bus.
// A CPU store to REG_ADDR copies LENGTH bytes from {src,8'h00} to OAM_BASE.
// Optional feature macro: OAM_DMA_BLOCK_EN. When defined, CPU accesses below
// FF00 are blocked while a transfer is active (loads read 8'hFF, stores are
// dropped). When undefined, every CPU access passes through and stalls the DMA.
//
// Strobe semantics: bus_load/bus_store are single-cycle requests that the
// downstream bus always accepts in the cycle they are asserted; read data
// comes back on bus_indata in the following cycle. CPU strobes follow the
// same rule, and cpu_outdata is valid the cycle after cpu_load.
module oam_dma #(
  parameter logic [15:0] REG_ADDR      = 16'hFF46,
  parameter logic [15:0] OAM_BASE      = 16'hFE00,
  parameter int          LENGTH        = 160,
  parameter int          STARTUP_DELAY = 1
) (
  input  logic        clockgb,
  input  logic        resetn,
  input  logic [15:0] cpu_address,
  input  logic [7:0]  cpu_indata,
  input  logic        cpu_load,
  input  logic        cpu_store,
  output logic [7:0]  cpu_outdata,
  output logic [15:0] bus_address,
  output logic [7:0]  bus_outdata,
  input  logic [7:0]  bus_indata,
  output logic        bus_load,
  output logic        bus_store,
  output logic        dma_active
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_READ  = 2'd2,
    S_WRITE = 2'd3
  } state_t;

  // Source of the last cpu_load: drives the cpu_outdata mux one cycle later.
  typedef enum logic [1:0] {
    SEL_BLOCK = 2'd0,
    SEL_PASS  = 2'd1,
    SEL_REG   = 2'd2
  } rsel_t;

  localparam logic [7:0] LAST_INDEX = 8'(LENGTH - 1);
  localparam logic [3:0] DELAY_LAST = 4'(STARTUP_DELAY - 1);
  localparam state_t     FIRST_STATE = (STARTUP_DELAY == 0) ? S_READ : S_START;

  state_t      r_state;
  rsel_t       r_rsel;
  logic [7:0]  r_src;
  logic [7:0]  r_index;
  logic [7:0]  r_dbuf;
  logic [3:0]  r_delay;
  logic        r_rd_pend;

  logic        w_reg_hit;
  logic        w_trigger;
  logic        w_cpu_acc;
  logic        w_cpu_fwd;
  logic        w_active;
  logic        w_dma_rd;
  logic        w_dma_wr;
  logic [7:0]  w_src_eff;
  logic [7:0]  w_wr_data;

  assign w_reg_hit = (cpu_address == REG_ADDR);
  assign w_trigger = cpu_store & w_reg_hit;
  // FF46 accesses are handled internally and never reach the bus.
  assign w_cpu_acc = (cpu_load | cpu_store) & ~w_reg_hit;
  assign w_active  = (r_state != S_IDLE);

`ifdef OAM_DMA_BLOCK_EN
  logic w_cpu_hi;
  assign w_cpu_hi  = (cpu_address[15:8] == 8'hFF);
  // Only the high page stays reachable while a transfer is running.
  assign w_cpu_fwd = w_cpu_acc & (w_cpu_hi | ~w_active);
`else
  assign w_cpu_fwd = w_cpu_acc;
`endif

  // Echo RAM sources (E0-FF) alias work RAM at C0-DF.
  assign w_src_eff = (r_src[7:5] == 3'b111) ? (r_src - 8'h20) : r_src;

  // A forwarded CPU access owns the bus; the DMA step simply repeats later.
  assign w_dma_rd  = (r_state == S_READ)  & ~w_cpu_fwd;
  assign w_dma_wr  = (r_state == S_WRITE) & ~w_cpu_fwd;

  // The first write attempt takes read data straight off the bus; any retry
  // uses the copy captured in r_dbuf, because bus_indata may have moved on.
  assign w_wr_data = r_rd_pend ? bus_indata : r_dbuf;

  assign dma_active = w_active;

  // Downstream bus mux: CPU passthrough when forwarded, otherwise DMA step.
  always_comb begin
    bus_load    = 1'b0;
    bus_store   = 1'b0;
    bus_address = 16'h0000;
    bus_outdata = 8'h00;
    if (w_cpu_fwd) begin
      bus_load    = cpu_load;
      bus_store   = cpu_store;
      bus_address = cpu_address;
      bus_outdata = cpu_indata;
    end else if (w_dma_rd) begin
      bus_load    = 1'b1;
      bus_address = {w_src_eff, r_index};
    end else if (w_dma_wr) begin
      bus_store   = 1'b1;
      bus_address = OAM_BASE + {8'h00, r_index};
      bus_outdata = w_wr_data;
    end
  end

  // CPU read data mux selected by what the previous cpu_load targeted.
  always_comb begin
    cpu_outdata = 8'hFF;
    case (r_rsel)
      SEL_PASS: cpu_outdata = bus_indata;
      SEL_REG:  cpu_outdata = r_src;
      default:  cpu_outdata = 8'hFF;
    endcase
  end

  // Transfer FSM, source register, read-data buffer and read-select tracking.
  always_ff @(posedge clockgb or negedge resetn) begin
    if (!resetn) begin
      r_state   <= S_IDLE;
      r_rsel    <= SEL_BLOCK;
      r_src     <= 8'hFF;
      r_index   <= 8'h00;
      r_dbuf    <= 8'h00;
      r_delay   <= 4'h0;
      r_rd_pend <= 1'b0;
    end else begin
      r_rd_pend <= w_dma_rd;
      if (r_rd_pend) begin
        r_dbuf <= bus_indata;
      end

      if (cpu_load) begin
        if (w_reg_hit) begin
          r_rsel <= SEL_REG;
        end else if (w_cpu_fwd) begin
          r_rsel <= SEL_PASS;
        end else begin
          r_rsel <= SEL_BLOCK;
        end
      end

      if (w_trigger) begin
        // A new trigger restarts from byte 0; any in-flight byte is dropped.
        r_src     <= cpu_indata;
        r_index   <= 8'h00;
        r_delay   <= 4'h0;
        r_rd_pend <= 1'b0;
        r_state   <= FIRST_STATE;
      end else begin
        case (r_state)
          S_START: begin
            // The start-up delay keeps counting even when the CPU owns the bus.
            if (r_delay == DELAY_LAST) begin
              r_state <= S_READ;
            end else begin
              r_delay <= r_delay + 4'h1;
            end
          end
          S_READ: begin
            if (!w_cpu_fwd) begin
              r_state <= S_WRITE;
            end
          end
          S_WRITE: begin
            if (!w_cpu_fwd) begin
              r_index <= r_index + 8'h01;
              r_state <= (r_index == LAST_INDEX) ? S_IDLE : S_READ;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_oam_dma.sv
// tb_oam_dma: directed scenarios for oam_dma with a behavioural memory and a
// queue-based scoreboard checking DMA bus traffic and CPU read data.
module tb_oam_dma;

  logic        clockgb = 1'b0;
  logic        resetn;
  logic [15:0] cpu_address;
  logic [7:0]  cpu_indata;
  logic        cpu_load;
  logic        cpu_store;
  logic [7:0]  cpu_outdata;
  logic [15:0] bus_address;
  logic [7:0]  bus_outdata;
  logic [7:0]  bus_indata;
  logic        bus_load;
  logic        bus_store;
  logic        dma_active;

  oam_dma dut (
    .clockgb     (clockgb),
    .resetn      (resetn),
    .cpu_address (cpu_address),
    .cpu_indata  (cpu_indata),
    .cpu_load    (cpu_load),
    .cpu_store   (cpu_store),
    .cpu_outdata (cpu_outdata),
    .bus_address (bus_address),
    .bus_outdata (bus_outdata),
    .bus_indata  (bus_indata),
    .bus_load    (bus_load),
    .bus_store   (bus_store),
    .dma_active  (dma_active)
  );

  // ---------------- clock ----------------
  always #5 clockgb = ~clockgb;

  // ---------------- memory model ----------------
  logic [7:0] mem [65536];
  bit         wvld [65536];

  function automatic logic [7:0] pat(input logic [15:0] a);
    return (a[7:0] * 8'd3) ^ a[15:8] ^ 8'h5A;
  endfunction

  function automatic logic [7:0] mem_rd(input logic [15:0] a);
    return wvld[a] ? mem[a] : pat(a);
  endfunction

  always @(posedge clockgb) begin
    if (bus_load) bus_indata <= mem_rd(bus_address);
    if (bus_store) begin
      mem[bus_address]  <= bus_outdata;
      wvld[bus_address] <= 1'b1;
    end
  end

  // ---------------- scoreboard ----------------
  logic [15:0] exp_rd_q[$];
  logic [23:0] exp_wr_q[$];
  logic [7:0]  exp_cpu_q[$];
  logic [7:0]  exp_oam [256];
  int n_checks = 0;
  int n_pass   = 0;
  int n_dma_wr = 0;
  int n_active = 0;
  logic cpu_rd_pend = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    $display("FAIL %s: got event missing/unexpected, expected none", name);
  endtask

  // Monitor: DMA traffic is any strobe not attributable to the CPU this cycle.
  always @(negedge clockgb) begin
    logic is_cpu;
    if (cpu_rd_pend) begin
      if (exp_cpu_q.size() == 0) fail_now("cpu_rd_unexpected");
      else chk("cpu_rd", 32'(cpu_outdata), 32'(exp_cpu_q.pop_front()));
    end
    cpu_rd_pend = cpu_load;
    is_cpu = (cpu_load | cpu_store) && (bus_address == cpu_address);
    if (dma_active) n_active++;
    if (dma_active && bus_load && !is_cpu) begin
      if (exp_rd_q.size() == 0) fail_now("dma_rd_unexpected");
      else chk("dma_rd_addr", 32'(bus_address), 32'(exp_rd_q.pop_front()));
    end
    if (dma_active && bus_store && !is_cpu) begin
      n_dma_wr++;
      if (exp_wr_q.size() == 0) fail_now("dma_wr_unexpected");
      else chk("dma_wr_addr_data", 32'({bus_address, bus_outdata}), 32'(exp_wr_q.pop_front()));
    end
  end

  // ---------------- driver tasks ----------------
  int base_wr;
  int base_act;

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clockgb);
      #1;
    end
  endtask

  task automatic cpu_store_t(input logic [15:0] a, input logic [7:0] d);
    cpu_address = a; cpu_indata = d; cpu_store = 1'b1;
    cyc(1);
    cpu_store = 1'b0; cpu_address = 16'h0000; cpu_indata = 8'h00;
  endtask

  task automatic cpu_load_t(input logic [15:0] a, input logic [7:0] exp);
    exp_cpu_q.push_back(exp);
    cpu_address = a; cpu_load = 1'b1;
    cyc(1);
    cpu_load = 1'b0; cpu_address = 16'h0000;
  endtask

  task automatic start_dma(input logic [7:0] src);
    logic [7:0] f;
    f = (src[7:5] == 3'b111) ? (src - 8'h20) : src;
    cpu_address = 16'hFF46; cpu_indata = src; cpu_store = 1'b1;
    @(negedge clockgb);
    chk("ff46_not_forwarded", 32'(bus_store), 32'd0);
    @(posedge clockgb);
    #1;
    cpu_store = 1'b0; cpu_address = 16'h0000; cpu_indata = 8'h00;
    chk("dma_active_rise", 32'(dma_active), 32'd1);
    exp_rd_q.delete();
    exp_wr_q.delete();
    for (int i = 0; i < 160; i++) begin
      logic [15:0] ra;
      ra = {f, 8'(i)};
      exp_oam[i] = mem_rd(ra);
      exp_rd_q.push_back(ra);
      exp_wr_q.push_back({16'hFE00 + 16'(i), exp_oam[i]});
    end
    base_wr  = n_dma_wr;
    base_act = n_active;
  endtask

  task automatic wait_idle();
    int t = 0;
    while (dma_active && t < 3000) begin cyc(1); t++; end
    if (dma_active) fail_now("idle_timeout");
  endtask

  task automatic wait_writes(input int n);
    int t = 0;
    while ((n_dma_wr - base_wr) < n && t < 3000) begin cyc(1); t++; end
    if ((n_dma_wr - base_wr) < n) fail_now("writes_timeout");
  endtask

  task automatic wait_wr_addr(input logic [15:0] a);
    int t = 0;
    while (!(bus_store && bus_address == a) && t < 3000) begin cyc(1); t++; end
    if (!(bus_store && bus_address == a)) fail_now("wr_addr_timeout");
  endtask

  task automatic check_oam(input string name);
    int bad = 0;
    for (int i = 0; i < 160; i++)
      if (mem_rd(16'hFE00 + 16'(i)) !== exp_oam[i]) bad++;
    chk(name, 32'(bad), 32'd0);
  endtask

  task automatic check_drained(input string name);
    chk(name, 32'(exp_rd_q.size() + exp_wr_q.size() + exp_cpu_q.size()), 32'd0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    resetn = 1'b0; cpu_address = 16'h0000; cpu_indata = 8'h00;
    cpu_load = 1'b0; cpu_store = 1'b0;
    cyc(3);
    chk("rst_dma_active", 32'(dma_active), 32'd0);
    chk("rst_bus_strobes", 32'({bus_load, bus_store}), 32'd0);
    chk("rst_bus_address", 32'(bus_address), 32'd0);
    chk("rst_bus_outdata", 32'(bus_outdata), 32'd0);
    chk("rst_cpu_outdata", 32'(cpu_outdata), 32'hFF);
    resetn = 1'b1;
    cyc(1);
    cpu_load_t(16'hFF46, 8'hFF);
    cyc(1);

    // Basic transfer from C1
    start_dma(8'hC1);
    wait_idle();
    chk("t1_active_cycles", 32'(n_active - base_act), 32'd321);
    check_oam("t1_oam");
    check_drained("t1_drained");
    cyc(2);

    // Echo fold E3 -> C3, plus CPU traffic during the transfer
    start_dma(8'hE3);
    wait_writes(20);
    cpu_load_t(16'hC000, `ifdef OAM_DMA_BLOCK_EN 8'hFF `else pat(16'hC000) `endif);
    cyc(3);
    cpu_store_t(16'hD000, 8'h55);
    cyc(3);
    cpu_load_t(16'hFF80, mem_rd(16'hFF80));
    wait_idle();
`ifdef OAM_DMA_BLOCK_EN
    chk("t2_active_cycles", 32'(n_active - base_act), 32'd322);
    chk("t2_d000_unchanged", 32'(mem_rd(16'hD000)), 32'(pat(16'hD000)));
`else
    chk("t2_active_cycles", 32'(n_active - base_act), 32'd324);
    chk("t2_d000_written", 32'(mem_rd(16'hD000)), 32'h55);
`endif
    check_oam("t2_oam");
    check_drained("t2_drained");
    cyc(2);

    // Retried writes: stall on FE05 (store) and FE0A (loads)
    start_dma(8'hC4);
    wait_wr_addr(16'hFE05);
    cpu_address = 16'hFF80; cpu_indata = 8'h77; cpu_store = 1'b1;
    cyc(3);
    cpu_store = 1'b0; cpu_address = 16'h0000; cpu_indata = 8'h00;
    wait_wr_addr(16'hFE0A);
    cpu_load_t(16'hFF81, mem_rd(16'hFF81));
    cpu_load_t(16'hFF81, mem_rd(16'hFF81));
    wait_idle();
    chk("t3_active_cycles", 32'(n_active - base_act), 32'd326);
    chk("t3_ff80_written", 32'(mem_rd(16'hFF80)), 32'h77);
    check_oam("t3_oam");
    check_drained("t3_drained");
    cyc(2);

    // Restart mid-transfer with a new source
    start_dma(8'hC0);
    wait_writes(50);
    start_dma(8'hD0);
    wait_idle();
    chk("t4_active_cycles", 32'(n_active - base_act), 32'd321);
    check_oam("t4_oam");
    cpu_load_t(16'hFF46, 8'hD0);
    cyc(2);
    check_drained("t4_drained");

    // Reset in the middle of a transfer, then a full new transfer
    start_dma(8'hC5);
    wait_writes(80);
    resetn = 1'b0;
    #1;
    chk("t5_rst_dma_active", 32'(dma_active), 32'd0);
    chk("t5_rst_bus_strobes", 32'({bus_load, bus_store}), 32'd0);
    chk("t5_rst_cpu_outdata", 32'(cpu_outdata), 32'hFF);
    exp_rd_q.delete();
    exp_wr_q.delete();
    cyc(2);
    resetn = 1'b1;
    cyc(1);
    cpu_load_t(16'hFF46, 8'hFF);
    cyc(1);
    start_dma(8'hC2);
    wait_idle();
    chk("t5_active_cycles", 32'(n_active - base_act), 32'd321);
    check_oam("t5_oam");
    cyc(2);
    check_drained("t5_drained");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
